tpu_tile_sequencer: RTL and testbench

TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

---
 rtl/tpu_tile_sequencer_pkg.sv | 10 +
 rtl/tpu_tile_sequencer_delay.sv | 14 +
 rtl/tpu_tile_sequencer.sv | 119 +++++++++++
 tb/tb_tpu_tile_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tpu_tile_sequencer_pkg.sv
// tpu_pkg: shared FSM state encoding, result latency and address-increment helper for the tile sequencer
package tpu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  function automatic int lat(input int matrix_size);
    return 2 * matrix_size;
  endfunction
  function automatic logic [31:0] addr_inc(input logic [31:0] a);
    return a + 32'd1;
  endfunction
endpackage

// File: rtl/tpu_tile_sequencer_delay.sv
// valid_delay_line: DEPTH-stage valid shift register; clk, rst/clr clear all stages, din enters, dout leaves DEPTH cycles later
module valid_delay_line #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk) sr <= (rst || clr) ? '0 : {sr[DEPTH-2:0], din};
  always_comb dout = sr[DEPTH-1];
endmodule

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: weight-load / stream / drain job sequencer; in: clk rst start abort src_base dst_base num_vec wslot; out: ub_re ub_addr wbuf_addr we_rl res_we res_addr busy done
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int MATRIX_SIZE  = 8,
  parameter int ADDRESSSIZE  = 10,
  parameter int WSLOT_BW     = 2,
  parameter int LEN_BW       = 10,
  parameter int WLOAD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [LEN_BW-1:0]      num_vec,
  input  logic [WSLOT_BW-1:0]    wslot,
  output logic                   ub_re,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic [WSLOT_BW-1:0]    wbuf_addr,
  output logic                   we_rl,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
  output logic                   done
);
  localparam int LAT = lat(MATRIX_SIZE);
  state_t state;
  logic [ADDRESSSIZE-1:0] raddr, waddr;
  logic [LEN_BW-1:0] rd_left, wr_left;
  logic [3:0] wl_cnt;
  logic kill, rd_fire, dout;
  // rd_fire is the value ub_re takes next cycle; feeding it to the line lets res_addr be registered alongside res_we
  always_comb begin
    kill = abort && state != IDLE;
    rd_fire = (state == LOAD_W && wl_cnt == 4'(WLOAD_CYCLES - 1)) || (state == STREAM && rd_left != '0);
  end
  valid_delay_line #(.DEPTH(LAT)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (kill),
    .din  (rd_fire),
    .dout (dout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ub_re     <= 1'b0;
      ub_addr   <= '0;
      wbuf_addr <= '0;
      we_rl     <= 1'b0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      raddr     <= '0;
      waddr     <= '0;
      rd_left   <= '0;
      wr_left   <= '0;
      wl_cnt    <= '0;
    end else if (kill) begin
      state  <= IDLE;
      ub_re  <= 1'b0;
      we_rl  <= 1'b0;
      res_we <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ub_re  <= rd_fire;
      res_we <= dout;
      we_rl  <= 1'b0;
      done   <= 1'b0;
      if (rd_fire) begin
        ub_addr <= raddr;
        raddr   <= ADDRESSSIZE'(addr_inc(32'(raddr)));
        rd_left <= rd_left - LEN_BW'(1);
      end
      if (dout) begin
        res_addr <= waddr;
        waddr    <= ADDRESSSIZE'(addr_inc(32'(waddr)));
        wr_left  <= wr_left - LEN_BW'(1);
      end
      case (state)
        IDLE: if (start && !abort) begin
          raddr   <= src_base;
          waddr   <= dst_base;
          rd_left <= num_vec;
          wr_left <= num_vec;
          wl_cnt  <= '0;
          busy    <= 1'b1;
          if (num_vec == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= LOAD_W;
            we_rl     <= 1'b1;
            wbuf_addr <= wslot;
          end
        end
        LOAD_W: if (rd_fire) state <= STREAM;
                else begin
                  wl_cnt <= wl_cnt + 4'd1;
                  we_rl  <= 1'b1;
                end
        STREAM: if (!rd_fire) state <= DRAIN;
        DRAIN: if (res_we && wr_left == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer: table-driven and randomized checks of the tile sequencer against a cycle-schedule model
module tb_tpu_tile_sequencer;
  localparam int MS = 8, AS = 10, WB = 2, LB = 10, WL = 1, LAT = 2 * MS;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [AS-1:0] src_base = '0, dst_base = '0;
  logic [LB-1:0] num_vec = '0;
  logic [WB-1:0] wslot = '0;
  logic ub_re, we_rl, res_we, busy, done;
  logic [AS-1:0] ub_addr, res_addr;
  logic [WB-1:0] wbuf_addr;
  int n_chk = 0, n_fail = 0;
  logic [AS-1:0] m_ub = '0, m_res = '0;
  logic [WB-1:0] m_wb = '0;
  typedef struct {
    logic [AS-1:0] src;
    logic [AS-1:0] dst;
    int n;
    logic [WB-1:0] ws;
    int kill;
    bit krst;
    int restart;
    int exp_done;
    int exp_wr;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  tpu_tile_sequencer #(.MATRIX_SIZE(MS), .ADDRESSSIZE(AS), .WSLOT_BW(WB), .LEN_BW(LB), .WLOAD_CYCLES(WL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .src_base(src_base), .dst_base(dst_base),
    .num_vec(num_vec), .wslot(wslot), .ub_re(ub_re), .ub_addr(ub_addr), .wbuf_addr(wbuf_addr),
    .we_rl(we_rl), .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask
  task automatic run_job(input vec_t v, output int done_at, output int wr_seen);
    int dc, term;
    bit dead, e_we, e_re, e_wr, e_done, e_busy;
    dc = v.n == 0 ? 1 : WL + v.n + LAT + 1;
    term = v.kill > 0 ? v.kill : dc;
    done_at = 0;
    wr_seen = 0;
    start = 1'b1;
    abort = 1'b0;
    src_base = v.src;
    dst_base = v.dst;
    num_vec = LB'(v.n);
    wslot = v.ws;
    for (int c = 1; c <= term + 1; c++) begin
      @(posedge clk);
      #1;
      dead   = v.kill > 0 && c > v.kill;
      e_we   = !dead && v.n > 0 && c <= WL;
      e_re   = !dead && v.n > 0 && c > WL && c <= WL + v.n;
      e_wr   = !dead && v.n > 0 && c > WL + LAT && c <= WL + v.n + LAT;
      e_done = !dead && c == dc;
      e_busy = !dead && c <= dc;
      if (dead && v.krst) begin
        m_ub = '0;
        m_res = '0;
        m_wb = '0;
      end
      if (e_we) m_wb = v.ws;
      if (e_re) m_ub = v.src + AS'(c - WL - 1);
      if (e_wr) m_res = v.dst + AS'(c - WL - 1 - LAT);
      chk("we_rl", c, 32'(we_rl), 32'(e_we));
      chk("wbuf_addr", c, 32'(wbuf_addr), 32'(m_wb));
      chk("ub_re", c, 32'(ub_re), 32'(e_re));
      chk("ub_addr", c, 32'(ub_addr), 32'(m_ub));
      chk("res_we", c, 32'(res_we), 32'(e_wr));
      chk("res_addr", c, 32'(res_addr), 32'(m_res));
      chk("done", c, 32'(done), 32'(e_done));
      chk("busy", c, 32'(busy), 32'(e_busy));
      if (done && done_at == 0) done_at = c;
      if (res_we) wr_seen++;
      rst   = v.krst && c == v.kill;
      abort = !v.krst && c == v.kill;
      start = c == v.restart;
      src_base = AS'($urandom);
      dst_base = AS'($urandom);
      num_vec  = LB'($urandom);
      wslot    = WB'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
  endtask
  initial begin
    int d, w, dc;
    vec_t v;
    tbl[0] = '{10'h010, 10'h200, 3, 2'd2, 0, 1'b0, 0, 21, 3};
    tbl[1] = '{10'h055, 10'h066, 0, 2'd1, 0, 1'b0, 0, 1, 0};
    tbl[2] = '{10'h3FE, 10'h3FF, 4, 2'd1, 0, 1'b0, 0, 22, 4};
    tbl[3] = '{10'h010, 10'h200, 3, 2'd2, 19, 1'b0, 0, 0, 2};
    tbl[4] = '{10'h010, 10'h200, 3, 2'd2, 0, 1'b0, 0, 21, 3};
    tbl[5] = '{10'h010, 10'h200, 3, 2'd2, 0, 1'b0, 3, 21, 3};
    tbl[6] = '{10'h123, 10'h321, 5, 2'd3, 3, 1'b1, 0, 0, 0};
    tbl[7] = '{10'h010, 10'h200, 3, 2'd2, 0, 1'b0, 0, 21, 3};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst ub_re", 0, 32'(ub_re), 0);
    chk("rst we_rl", 0, 32'(we_rl), 0);
    chk("rst res_we", 0, 32'(res_we), 0);
    chk("rst busy", 0, 32'(busy), 0);
    chk("rst done", 0, 32'(done), 0);
    chk("rst ub_addr", 0, 32'(ub_addr), 0);
    chk("rst res_addr", 0, 32'(res_addr), 0);
    chk("rst wbuf_addr", 0, 32'(wbuf_addr), 0);
    start = 1'b1;
    abort = 1'b1;
    num_vec = LB'(3);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      chk("idle abort busy", c, 32'(busy), 0);
      chk("idle abort we_rl", c, 32'(we_rl), 0);
      chk("idle abort done", c, 32'(done), 0);
    end
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i], d, w);
      chk($sformatf("row%0d done_cycle", i), 0, 32'(d), 32'(tbl[i].exp_done));
      chk($sformatf("row%0d writes", i), 0, 32'(w), 32'(tbl[i].exp_wr));
    end
    for (int j = 0; j < 25; j++) begin
      v.src = AS'($urandom);
      v.dst = AS'($urandom);
      v.n = int'($urandom_range(0, 12));
      v.ws = WB'($urandom);
      dc = v.n == 0 ? 1 : WL + v.n + LAT + 1;
      v.kill = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dc)) : 0;
      v.krst = 1'($urandom_range(0, 1));
      v.restart = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, v.kill > 0 ? v.kill : dc)) : 0;
      v.exp_done = 0;
      v.exp_wr = 0;
      run_job(v, d, w);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
